// File: rtl/alu_mc_pkg.sv
// Shared constants for the multi-cycle ALU: opcodes, FSM state encodings and flag bit positions.
package alu_mc_pkg;

  typedef logic [3:0] opcode_t;

  localparam opcode_t OP_PASS_B = 4'b0001;
  localparam opcode_t OP_ADD    = 4'b0010;
  localparam opcode_t OP_SUB    = 4'b0011;
  localparam opcode_t OP_AND    = 4'b0100;
  localparam opcode_t OP_OR     = 4'b0101;
  localparam opcode_t OP_XOR    = 4'b0110;
  localparam opcode_t OP_NOT    = 4'b0111;
  localparam opcode_t OP_SHR1   = 4'b1000;
  localparam opcode_t OP_SHL1   = 4'b1001;
  localparam opcode_t OP_IMM    = 4'b1010;
  localparam opcode_t OP_ADDI   = 4'b1011;
  localparam opcode_t OP_ACC    = 4'b1100;
  localparam opcode_t OP_MUL    = 4'b1101;
  localparam opcode_t OP_SHLV   = 4'b1110;
  localparam opcode_t OP_SAR1   = 4'b1111;

  localparam int unsigned STATE_W = 2;
  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_CALC = 2'd1;
  localparam logic [STATE_W-1:0] ST_DONE = 2'd2;

  // Bit positions inside the {N,Z,C,V} flags vector
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/alu_mc_mul.sv
// Radix-2 shift-add signed multiplier producing the full 2*DATA_SIZE product.
// Only built when ALU_MC_MUL_EN is defined.
`ifdef ALU_MC_MUL_EN
module alu_mc_mul #(
  parameter int unsigned DATA_SIZE = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   step,
  input  logic [DATA_SIZE-1:0]   a,
  input  logic [DATA_SIZE-1:0]   b,
  output logic                   last_c,
  output logic [2*DATA_SIZE-1:0] product
);
  localparam int unsigned CNT_W = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
  localparam int unsigned PW    = 2 * DATA_SIZE;

  logic [CNT_W-1:0]     count;
  logic [PW-1:0]        mcand;
  logic [DATA_SIZE-1:0] mplier;
  logic [PW-1:0]        addend_c;
  logic                 final_c;

  assign final_c = (count == CNT_W'(DATA_SIZE - 1));
  assign last_c  = step && final_c;

  // The multiplier's sign bit carries negative weight, so its partial product is subtracted
  always_comb begin
    addend_c = '0;
    if (mplier[0]) addend_c = final_c ? (~mcand + PW'(1)) : mcand;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
    end else if (load) begin
      count   <= '0;
      mcand   <= PW'($signed(a));
      mplier  <= b;
      product <= '0;
    end else if (step) begin
      count   <= count + CNT_W'(1);
      mcand   <= mcand << 1;
      mplier  <= mplier >> 1;
      product <= product + addend_c;
    end
  end

endmodule
`endif

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ops finish through DONE, signed MUL iterates in CALC.
// Define ALU_MC_MUL_EN to build the multiplier and CALC state; otherwise opcode 1101 passes A.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int unsigned DATA_SIZE   = 8,
  parameter int unsigned OPCODE_SIZE = 4,
  parameter int unsigned INSTR_SIZE  = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [INSTR_SIZE-1:0] instr_reg,
  input  logic [DATA_SIZE-1:0]  accumulator,
  input  logic [DATA_SIZE-1:0]  from_mem_data,
  output logic [DATA_SIZE-1:0]  alu_out,
  output logic                  we_alu,
  output logic                  busy,
  output logic                  done,
  output logic [3:0]            flags
);
  localparam int unsigned MSB = DATA_SIZE - 1;
  localparam int unsigned SHW = $clog2(DATA_SIZE);

  logic [STATE_W-1:0]     state_q, state_d;
  logic [OPCODE_SIZE-1:0] instr_op_c;
  logic [OPCODE_SIZE-1:0] op_q;
  logic [DATA_SIZE-1:0]   imm_q, a_q, b_q;
  logic                   accept_c;
  logic [DATA_SIZE-1:0]   res_c;
  logic [DATA_SIZE:0]     wide_c;
  logic                   carry_c, ovf_c;
  logic [3:0]             flags_c;

  assign instr_op_c = instr_reg[INSTR_SIZE-1 -: OPCODE_SIZE];

`ifdef ALU_MC_MUL_EN
  logic                   mul_last_c;
  logic [2*DATA_SIZE-1:0] mul_prod;
  logic                   mul_load_c;
  logic                   mul_step_c;

  assign mul_load_c = accept_c && (instr_op_c == OPCODE_SIZE'(OP_MUL));
  assign mul_step_c = (state_q == ST_CALC);

  alu_mc_mul #(
    .DATA_SIZE (DATA_SIZE)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .load    (mul_load_c),
    .step    (mul_step_c),
    .a       (accumulator),
    .b       (from_mem_data),
    .last_c  (mul_last_c),
    .product (mul_prod)
  );
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; start is only honoured in IDLE
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept_c = 1'b1;
          state_d  = ST_DONE;
`ifdef ALU_MC_MUL_EN
          if (instr_op_c == OPCODE_SIZE'(OP_MUL)) state_d = ST_CALC;
`endif
        end
      end
`ifdef ALU_MC_MUL_EN
      ST_CALC: if (mul_last_c) state_d = ST_DONE;
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand capture at acceptance; inputs are ignored afterwards
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q  <= '0;
      imm_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else if (accept_c) begin
      op_q  <= instr_op_c;
      imm_q <= instr_reg[DATA_SIZE-1:0];
      a_q   <= accumulator;
      b_q   <= from_mem_data;
    end
  end

  // Result and flag computation from the latched operands
  always_comb begin
    res_c   = a_q;
    wide_c  = '0;
    carry_c = 1'b0;
    ovf_c   = 1'b0;
    case (op_q)
      OPCODE_SIZE'(OP_PASS_B): res_c = b_q;
      OPCODE_SIZE'(OP_ADD): begin
        wide_c  = {1'b0, a_q} + {1'b0, b_q};
        res_c   = wide_c[MSB:0];
        carry_c = wide_c[DATA_SIZE];
        ovf_c   = (a_q[MSB] == b_q[MSB]) && (res_c[MSB] != a_q[MSB]);
      end
      OPCODE_SIZE'(OP_SUB): begin
        wide_c  = {1'b0, a_q} - {1'b0, b_q};
        res_c   = wide_c[MSB:0];
        carry_c = wide_c[DATA_SIZE];
        ovf_c   = (a_q[MSB] != b_q[MSB]) && (res_c[MSB] != a_q[MSB]);
      end
      OPCODE_SIZE'(OP_AND):  res_c = a_q & b_q;
      OPCODE_SIZE'(OP_OR):   res_c = a_q | b_q;
      OPCODE_SIZE'(OP_XOR):  res_c = a_q ^ b_q;
      OPCODE_SIZE'(OP_NOT):  res_c = ~a_q;
      OPCODE_SIZE'(OP_SHR1): res_c = {1'b0, a_q[MSB:1]};
      OPCODE_SIZE'(OP_SHL1): begin
        res_c   = {a_q[MSB-1:0], 1'b0};
        carry_c = a_q[MSB];
      end
      OPCODE_SIZE'(OP_IMM):  res_c = imm_q;
      OPCODE_SIZE'(OP_ADDI): begin
        wide_c  = {1'b0, a_q} + {1'b0, imm_q};
        res_c   = wide_c[MSB:0];
        carry_c = wide_c[DATA_SIZE];
        ovf_c   = (a_q[MSB] == imm_q[MSB]) && (res_c[MSB] != a_q[MSB]);
      end
      OPCODE_SIZE'(OP_ACC):  res_c = a_q;
`ifdef ALU_MC_MUL_EN
      OPCODE_SIZE'(OP_MUL): begin
        res_c = mul_prod[MSB:0];
        ovf_c = (mul_prod[2*DATA_SIZE-1:DATA_SIZE] != {DATA_SIZE{mul_prod[MSB]}});
      end
`endif
      OPCODE_SIZE'(OP_SHLV): res_c = a_q << imm_q[SHW-1:0];
      OPCODE_SIZE'(OP_SAR1): res_c = {a_q[MSB], a_q[MSB:1]};
      default:               res_c = a_q;
    endcase
    flags_c         = '0;
    flags_c[FLAG_N] = res_c[MSB];
    flags_c[FLAG_Z] = (res_c == '0);
    flags_c[FLAG_C] = carry_c;
    flags_c[FLAG_V] = ovf_c;
  end

  // Registered results; alu_out and flags hold until the next DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_out <= '0;
      flags   <= '0;
      done    <= 1'b0;
      we_alu  <= 1'b0;
    end else begin
      done   <= (state_q == ST_DONE);
      we_alu <= (state_q == ST_DONE) && (op_q == OPCODE_SIZE'(OP_ACC));
      if (state_q == ST_DONE) begin
        alu_out <= res_c;
        flags   <= flags_c;
      end
    end
  end

`ifdef ALU_MC_MUL_EN
  always_ff @(posedge clk) begin
    if (rst) busy <= 1'b0;
    else     busy <= (state_d == ST_CALC);
  end
`else
  assign busy = 1'b0;
`endif

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 8, operand/result width (>=4).
REQ-002 SHALL have parameter OPCODE_SIZE, default 4, opcode field width (top bits of instr_reg).
REQ-003 SHALL have parameter INSTR_SIZE, default 12, instruction width (>= OPCODE_SIZE + DATA_SIZE).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  request; accepted only in IDLE.
REQ-007 SHALL have port instr_reg  input  INSTR_SIZE  instruction; opcode = top OPCODE_SIZE bits, immediate = low DATA_SIZE bits.
REQ-008 SHALL have port accumulator  input  DATA_SIZE  signed operand A.
REQ-009 SHALL have port from_mem_data  input  DATA_SIZE  signed operand B.
REQ-010 SHALL have port alu_out  output  DATA_SIZE  registered signed result.
REQ-011 SHALL have port we_alu  output  1  store-accumulator strobe, pulses with done.
REQ-012 SHALL have port busy  output  1  high in CALC state.
REQ-013 SHALL have port done  output  1  one-cycle result-valid pulse.
REQ-014 SHALL have port flags  output  4  {N,Z,C,V}, registered.

Function
REQ-015 SHALL latch opcode, immediate, accumulator, from_mem_data on the cycle start is accepted; later input changes ignored until done.
REQ-016 SHALL implement FSM IDLE -> (start, 1-cycle op) DONE; IDLE -> (start, MUL) CALC; CALC -> (counter = DATA_SIZE-1) DONE; DONE -> IDLE unconditionally.
REQ-017 SHALL assert done for exactly the DONE cycle; 1-cycle ops: start at edge N, done high after edge N+1; MUL: done high after edge N+DATA_SIZE+1.
REQ-018 SHALL ignore start while in CALC or DONE (no queuing).
REQ-019 SHALL compute: 0001 B; 0010 A+B; 0011 A-B; 0100 A&B; 0101 A|B; 0110 A^B; 0111 ~A; 1000 A>>1 logical; 1001 A<<1; 1010 imm; 1011 A+imm; 1100 A with we_alu=1; 1110 A<<imm[log2(DATA_SIZE)-1:0] barrel; 1111 A>>>1 arithmetic; all others A.
REQ-020 SHALL implement 1101 MUL as signed A*B, low DATA_SIZE bits, via radix-2 shift-add over DATA_SIZE CALC cycles.
REQ-021 SHALL wrap all results modulo 2^DATA_SIZE.
REQ-022 SHALL update flags only in DONE: N=result MSB, Z=(result==0); C=carry-out for add/sub/shift-left-1, else 0; V=signed overflow for add/sub, high-half-nonzero-sign-mismatch for MUL, else 0.
REQ-023 SHALL hold alu_out and flags between operations; we_alu high only in DONE of opcode 1100.

Reset
REQ-024 SHALL, on rst at any edge including mid-CALC, enter IDLE, abort the operation, clear alu_out, flags, counter, busy, done, we_alu to 0, with no done pulse for the aborted op.
REQ-025 SHALL give rst priority over start in the same cycle.

Configuration
REQ-026 SHALL compile MUL and CALC state only when ALU_MC_MUL_EN is defined.
REQ-027 SHALL, without ALU_MC_MUL_EN, treat 1101 as default (A, 1-cycle), busy constant 0.

Structure
REQ-028 SHALL place opcode constants, FSM state enum and flag bit indices in package alu_mc_pkg.
REQ-029 SHALL place the shift-add multiplier datapath in sub-module alu_mc_mul (start, operands, counter, product).

Verification (DATA_SIZE=8)
REQ-030 SHALL check add: A=0x7F, B=0x01, op 0010 -> alu_out 0x80, done 1 cycle after start, flags N=1 Z=0 C=0 V=1.
REQ-031 SHALL check MUL: A=-3 (0xFD), B=5 -> alu_out 0xF1 (-15), done exactly 9 cycles after start, busy high 8 cycles.
REQ-032 SHALL check start pulses during CALC ignored: second start at cycle 3 of MUL -> single done, result of first op.
REQ-033 SHALL check rst at CALC cycle 4 -> next cycle all outputs 0, no done; fresh start then completes normally.
REQ-034 SHALL check op 1100 with A=0x5A -> alu_out 0x5A, we_alu=1 and done=1 same single cycle.
REQ-035 SHALL check barrel op 1110, A=0x03, imm=0x07 -> 0x80; sub 0x00-0x01 -> 0xFF, C per borrow rule, N=1.
